fbuff_pattern_init: RTL and testbench
=====================================

FBUFF_PATTERN_INIT -- requirements
Module: fbuff_pattern_init

Interface
REQ-001 SHALL have parameter PXL_WIDTH, default 12, bits per tile pixel (3 colour channels).
REQ-002 SHALL have parameter DEPTH_COLR, default 4, bits per colour channel (PXL_WIDTH = 3*DEPTH_COLR).
REQ-003 SHALL have parameter TILE_PER_ROW, default 5, tiles packed per frame-buffer row.
REQ-004 SHALL have parameter TILE_PER_LINE, default 160, tiles per display tile-line (multiple of TILE_PER_ROW).
REQ-005 SHALL have parameter FBUFF_DEPTH, default 19200, frame-buffer rows.
REQ-006 SHALL derive FBUFF_ADDR_WIDTH = $clog2(FBUFF_DEPTH) and FBUFF_DATA_WIDTH = TILE_PER_ROW*PXL_WIDTH.
REQ-007 SHALL have port clk_i, input, 1, the single clock.
REQ-008 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-009 SHALL have port start_i, input, 1, request to begin initialisation.
REQ-010 SHALL have port abort_i, input, 1, cancels a running initialisation.
REQ-011 SHALL have port mode_i, input, 2, pattern select: 0 SOLID, 1 RAMP, 2 CHECKER, 3 treated as SOLID.
REQ-012 SHALL have port fill_colr_i, input, PXL_WIDTH, base colour for SOLID and CHECKER.
REQ-013 SHALL have port grant_i, input, 1, frame-buffer port granted by the arbiter.
REQ-014 SHALL have ports fbuff_addr_o (FBUFF_ADDR_WIDTH), fbuff_data_o (FBUFF_DATA_WIDTH), fbuff_en_o (1) and fbuff_wen_o (1), all outputs, the frame-buffer write port.
REQ-015 SHALL have outputs busy_o (1, in WRITE), done_o (1, single-cycle completion pulse) and init_done_o (1, sticky completion flag).

Function
REQ-016 SHALL implement FSM states IDLE, WRITE and DONE.
REQ-017 IDLE -> WRITE on start_i=1: latch mode_i and fill_colr_i; clear the row address, tile column/line counters and ramp counter; clear init_done_o.
REQ-018 start_i SHALL be ignored outside IDLE.
REQ-019 In WRITE: fbuff_en_o = fbuff_wen_o = grant_i (combinational). Address and pattern counters advance only on cycles with grant_i=1.
REQ-020 With grant_i=0, address and data SHALL hold their values, so no row is skipped or duplicated.
REQ-021 The first write (address 0) SHALL be presented in the cycle after start is accepted. One row is written per granted cycle.
REQ-022 On a granted write of address FBUFF_DEPTH-1: WRITE -> DONE. In DONE, done_o=1 for exactly one cycle, init_done_o is set, and the FSM returns to IDLE.
REQ-023 init_done_o SHALL hold 1 until the next accepted start, rst_i or abort.
REQ-024 abort_i=1 in WRITE SHALL force IDLE next cycle with no done pulse; init_done_o stays 0. abort_i SHALL have priority over a simultaneous final write, which is then not performed.
REQ-025 SOLID: every tile SHALL be fill_colr.
REQ-026 RAMP: all tiles of row r SHALL be {3{c}}, where c is a triangle counter over DEPTH_COLR bits.
REQ-027 The RAMP counter SHALL start at 0 and step once per written row: 0,1,...,max,max-1,...,0,1,... Direction reverses at max and at 0, and each endpoint is emitted once per turn.
REQ-028 CHECKER: tile at column x, tile-line y SHALL be ~fill_colr when (x^y)[0]=1, otherwise fill_colr.
REQ-029 For CHECKER, x = row_in_line*TILE_PER_ROW + tile index, and y increments when row_in_line wraps at TILE_PER_LINE/TILE_PER_ROW-1.
REQ-030 Tile k of a row SHALL occupy fbuff_data_o[k*PXL_WIDTH +: PXL_WIDTH].
REQ-031 Outside WRITE, fbuff_en_o, fbuff_wen_o and fbuff_data_o SHALL be 0.

Reset
REQ-032 On rst_i=1 at a rising clk_i edge: FSM to IDLE; all counters 0; busy_o, done_o, init_done_o, fbuff_en_o, fbuff_wen_o, fbuff_addr_o and fbuff_data_o all 0.
REQ-033 Reset mid-WRITE SHALL abandon the fill without a done pulse; rst_i SHALL take priority over start_i and abort_i.

Structure
REQ-034 The mode and FSM-state enum typedefs and the mode constants SHALL reside in the shared VGA package.
REQ-035 The RAMP triangle counter SHALL be a sub-module tri_cntr (parameter WIDTH, inputs clr/step, output value).

Verification
REQ-036 Use DEPTH=8, TILE_PER_ROW=2, TILE_PER_LINE=4, and the default colour depth (max=0xF) throughout.
REQ-037 SOLID, fill=0x5A3, grant=1: addresses 0..7 on 8 consecutive cycles, each data 0x5A35A3; done pulse in cycle 9; init_done=1.
REQ-038 RAMP, DEPTH=40: row values 0x000,0x111,...,0xFFF,0xEEE,...,0x000,0x111; row 15 = 0xFFF and row 30 = 0x000.
REQ-039 CHECKER, fill=0x000: rows 0..7 data = 0xFFF000, 0xFFF000, 0x000FFF, 0x000FFF, repeating.
REQ-040 grant toggling 1,0,0,1... during RAMP: each address written exactly once, in order, with correct data.
REQ-041 abort at address 5 -> IDLE next cycle, no done, init_done=0. Then rst_i mid-fill -> all outputs 0. Then start_i in WRITE -> ignored.

Source files
------------

// File: rtl/fbuff_pattern_init_pkg.sv
// Shared VGA definitions: pattern modes, init FSM state encoding and a sizing helper.
package fbuff_pattern_init_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID     = 2'd0,
        MODE_RAMP      = 2'd1,
        MODE_CHECKER   = 2'd2,
        MODE_SOLID_ALT = 2'd3
    } pat_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } init_state_e;

    // Counter width that stays legal when the count range collapses to a single value.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fbuff_pattern_init_tri_cntr.sv
// Up/down triangle counter: 0..max..0, each endpoint emitted once per turn.
module tri_cntr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH-1:0] cnt_q;
    logic             down_q;

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst || clr) begin
            cnt_q  <= '0;
            down_q <= 1'b0;
        end else if (step) begin
            if (!down_q) begin
                if (cnt_q == MAX_VAL) begin
                    cnt_q  <= cnt_q - 1'b1;
                    down_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_q  <= cnt_q + 1'b1;
                    down_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign value = cnt_q;

endmodule

// File: rtl/fbuff_pattern_init.sv
// Fills the tile frame buffer with a SOLID, RAMP or CHECKER pattern, one row per granted cycle.
module fbuff_pattern_init
    import fbuff_pattern_init_pkg::*;
#(
    parameter  int PXL_WIDTH        = 12,
    parameter  int DEPTH_COLR       = 4,
    parameter  int TILE_PER_ROW     = 5,
    parameter  int TILE_PER_LINE    = 160,
    parameter  int FBUFF_DEPTH      = 19200,
    localparam int FBUFF_ADDR_WIDTH = $clog2(FBUFF_DEPTH),
    localparam int FBUFF_DATA_WIDTH = TILE_PER_ROW * PXL_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic                        abort_i,
    input  logic [1:0]                  mode_i,
    input  logic [PXL_WIDTH-1:0]        fill_colr_i,
    input  logic                        grant_i,
    output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_o,
    output logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_o,
    output logic                        fbuff_en_o,
    output logic                        fbuff_wen_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        init_done_o
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_WRITE = ST_WRITE;
    localparam logic [1:0] S_DONE  = ST_DONE;

    localparam int ROWS_PER_LINE = TILE_PER_LINE / TILE_PER_ROW;
    localparam int COL_WIDTH     = min1_clog2(ROWS_PER_LINE);

    localparam logic [FBUFF_ADDR_WIDTH-1:0] LAST_ADDR = FBUFF_ADDR_WIDTH'(FBUFF_DEPTH - 1);
    localparam logic [COL_WIDTH-1:0]        LAST_COL  = COL_WIDTH'(ROWS_PER_LINE - 1);

    logic [1:0]                  state_q;
    pat_mode_e                   mode_q;
    logic [PXL_WIDTH-1:0]        fill_q;
    logic [FBUFF_ADDR_WIDTH-1:0] addr_q;
    logic [COL_WIDTH-1:0]        col_q;
    logic                        line_odd_q;
    logic                        init_done_q;

    logic                        in_write;
    logic                        start_ok;
    logic                        wr_fire;
    logic [DEPTH_COLR-1:0]       ramp_val;
    logic [FBUFF_DATA_WIDTH-1:0] pattern;
    int unsigned                 tile_x;

    assign in_write = (state_q == S_WRITE);
    assign start_ok = (state_q == S_IDLE) && start_i;
    // An abort in the same cycle as a grant suppresses that write entirely.
    assign wr_fire  = in_write && grant_i && !abort_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_SOLID;
            fill_q      <= '0;
            addr_q      <= '0;
            col_q       <= '0;
            line_odd_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        state_q     <= S_WRITE;
                        mode_q      <= pat_mode_e'(mode_i);
                        fill_q      <= fill_colr_i;
                        addr_q      <= '0;
                        col_q       <= '0;
                        line_odd_q  <= 1'b0;
                        init_done_q <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (abort_i) begin
                        state_q <= S_IDLE;
                    end else if (grant_i) begin
                        addr_q <= addr_q + 1'b1;
                        if (col_q == LAST_COL) begin
                            col_q      <= '0;
                            line_odd_q <= ~line_odd_q;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                        if (addr_q == LAST_ADDR) begin
                            state_q     <= S_DONE;
                            addr_q      <= '0;
                            init_done_q <= 1'b1;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
            if (abort_i) begin
                init_done_q <= 1'b0;
            end
        end
    end

    tri_cntr #(
        .WIDTH (DEPTH_COLR)
    ) u_ramp (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (start_ok),
        .step  (wr_fire),
        .value (ramp_val)
    );

    always_comb begin
        // NOTE: defaults first so no path through the loop/case leaves a latch behind.
        pattern = '0;
        tile_x  = 0;
        for (int k = 0; k < TILE_PER_ROW; k++) begin
            tile_x = int'(col_q) * TILE_PER_ROW + k;
            case (mode_q)
                MODE_RAMP:
                    pattern[k*PXL_WIDTH +: PXL_WIDTH] = PXL_WIDTH'({3{ramp_val}});
                MODE_CHECKER:
                    pattern[k*PXL_WIDTH +: PXL_WIDTH] = (tile_x[0] ^ line_odd_q) ? ~fill_q : fill_q;
                default:
                    pattern[k*PXL_WIDTH +: PXL_WIDTH] = fill_q;
            endcase
        end
    end

    assign fbuff_addr_o = addr_q;
    assign fbuff_data_o = in_write ? pattern : '0;
    assign fbuff_en_o   = wr_fire;
    assign fbuff_wen_o  = wr_fire;
    assign busy_o       = in_write;
    assign done_o       = (state_q == S_DONE);
    assign init_done_o  = init_done_q;

endmodule

// File: tb/tb_fbuff_pattern_init.sv
// Directed bench: two instances (8 and 40 rows), 2 tiles/row, 2 rows per tile-line.
module tb_fbuff_pattern_init;

    logic        clk = 1'b0;
    logic        rst_i, start8, start40, abort_i, grant_i;
    logic [1:0]  mode_i;
    logic [11:0] fill_i;

    logic [2:0]  a8;
    logic [5:0]  a40;
    logic [23:0] d8, d40;
    logic        en8, wen8, busy8, done8, idone8;
    logic        en40, wen40, busy40, done40, idone40;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fbuff_pattern_init #(
        .PXL_WIDTH(12), .DEPTH_COLR(4), .TILE_PER_ROW(2), .TILE_PER_LINE(4), .FBUFF_DEPTH(8)
    ) dut8 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start8), .abort_i(abort_i), .mode_i(mode_i),
        .fill_colr_i(fill_i), .grant_i(grant_i), .fbuff_addr_o(a8), .fbuff_data_o(d8),
        .fbuff_en_o(en8), .fbuff_wen_o(wen8), .busy_o(busy8), .done_o(done8),
        .init_done_o(idone8)
    );

    fbuff_pattern_init #(
        .PXL_WIDTH(12), .DEPTH_COLR(4), .TILE_PER_ROW(2), .TILE_PER_LINE(4), .FBUFF_DEPTH(40)
    ) dut40 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start40), .abort_i(abort_i), .mode_i(mode_i),
        .fill_colr_i(fill_i), .grant_i(grant_i), .fbuff_addr_o(a40), .fbuff_data_o(d40),
        .fbuff_en_o(en40), .fbuff_wen_o(wen40), .busy_o(busy40), .done_o(done40),
        .init_done_o(idone40)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Triangle 0..15..0 has period 30; a row is its 4-bit value replicated six times.
    function automatic logic [23:0] ramp_row(input int r);
        int m;
        int c;
        m = r % 30;
        c = (m <= 15) ? m : 30 - m;
        return 24'(c) * 24'h111111;
    endfunction

    logic [23:0] chk_tab [4] = '{24'hFFF000, 24'hFFF000, 24'h000FFF, 24'h000FFF};

    initial begin
        int nr;
        int cyc;
        bit done_seen;

        rst_i = 1'b1; start8 = 1'b0; start40 = 1'b0; abort_i = 1'b0;
        grant_i = 1'b0; mode_i = 2'd0; fill_i = 12'h000;
        tick(); tick();
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_idone", idone8, 0);
        check("rst_en", en8, 0);
        check("rst_wen", wen8, 0);
        check("rst_addr", a8, 0);
        check("rst_data", d8, 0);
        check("rst_addr40", a40, 0);
        check("rst_busy40", busy40, 0);

        // SOLID: eight back-to-back rows, done in the ninth cycle after start.
        mode_i = 2'd0; fill_i = 12'h5A3; grant_i = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("solid_en", en8, 1);
            check("solid_wen", wen8, 1);
            check("solid_busy", busy8, 1);
            check("solid_addr", a8, i);
            check("solid_data", d8, 24'h5A35A3);
            check("solid_nodone", done8, 0);
            tick();
        end
        @(negedge clk);
        check("solid_done", done8, 1);
        check("solid_idone", idone8, 1);
        check("solid_busy_off", busy8, 0);
        check("solid_en_off", en8, 0);
        check("solid_data_off", d8, 0);
        tick();
        @(negedge clk);
        check("solid_done_pulse", done8, 0);
        check("solid_idone_hold", idone8, 1);

        // CHECKER with black fill.
        mode_i = 2'd2; fill_i = 12'h000; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        @(negedge clk);
        check("chk_idone_clr", idone8, 0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check("chk_addr", a8, i);
            check("chk_data", d8, chk_tab[i % 4]);
            tick();
        end
        @(negedge clk);
        check("chk_done", done8, 1);
        tick();

        // RAMP over 40 rows with continuous grant.
        mode_i = 2'd1; start40 = 1'b1;
        tick();
        start40 = 1'b0;
        for (int r = 0; r < 40; r++) begin
            @(negedge clk);
            check("ramp_addr", a40, r);
            check("ramp_data", d40, ramp_row(r));
            tick();
        end
        @(negedge clk);
        check("ramp_done", done40, 1);
        check("ramp_idone", idone40, 1);
        tick();

        // RAMP with grant pattern 1,0,0 repeating.
        start40 = 1'b1;
        tick();
        start40 = 1'b0;
        nr = 0; cyc = 0; done_seen = 1'b0;
        while (!done_seen && cyc < 300) begin
            grant_i = (cyc % 3 == 0);
            @(negedge clk);
            if (done40) begin
                done_seen = 1'b1;
            end else begin
                check("gt_addr", a40, nr);
                check("gt_wen", wen40, grant_i);
                if (en40) begin
                    check("gt_data", d40, ramp_row(nr));
                    nr++;
                end
            end
            tick();
            cyc++;
        end
        check("gt_done_seen", done_seen, 1);
        check("gt_rows", nr, 40);
        grant_i = 1'b1;

        // Abort while row 5 is presented.
        mode_i = 2'd0; fill_i = 12'h123; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (5) tick();
        abort_i = 1'b1;
        @(negedge clk);
        check("abort_addr", a8, 5);
        check("abort_busy", busy8, 1);
        tick();
        abort_i = 1'b0;
        @(negedge clk);
        check("abort_idle", busy8, 0);
        check("abort_nodone", done8, 0);
        check("abort_idone", idone8, 0);
        check("abort_en", en8, 0);
        check("abort_data", d8, 0);
        tick();
        @(negedge clk);
        check("abort_nodone2", done8, 0);

        // Reset mid-fill, asserted together with start.
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        rst_i = 1'b1; start8 = 1'b1;
        tick();
        rst_i = 1'b0; start8 = 1'b0;
        @(negedge clk);
        check("mrst_busy", busy8, 0);
        check("mrst_addr", a8, 0);
        check("mrst_data", d8, 0);
        check("mrst_en", en8, 0);
        check("mrst_done", done8, 0);
        check("mrst_idone", idone8, 0);

        // Mode 3 acts as SOLID; a second start during WRITE is ignored.
        mode_i = 2'd3; fill_i = 12'hABC; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        @(negedge clk);
        check("m3_addr", a8, 0);
        check("m3_data", d8, 24'hABCABC);
        tick(); tick();
        start8 = 1'b1; mode_i = 2'd2; fill_i = 12'h000;
        @(negedge clk);
        check("restart_addr_a", a8, 2);
        tick();
        start8 = 1'b0;
        @(negedge clk);
        check("restart_addr_b", a8, 3);
        check("restart_busy", busy8, 1);
        check("restart_data", d8, 24'hABCABC);
        cyc = 0;
        while (!done8 && cyc < 20) begin
            tick();
            @(negedge clk);
            cyc++;
        end
        check("restart_done", done8, 1);
        check("restart_idone", idone8, 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
